// File: rtl/reg_file_4x4_if.sv
// Bus bundle between the CPU write/read path and the 4x4 register bank.
// master drives write enables, data and selects; slave returns the registered read data and err.
interface reg_file_4x4_if #(
  parameter int WIDTH = 4
);
  logic [3:0]       we;
  logic [WIDTH-1:0] wdata;
  logic [1:0]       ra_sel;
  logic [1:0]       rb_sel;
  logic             err_clr;
  logic [WIDTH-1:0] ra_data;
  logic [WIDTH-1:0] rb_data;
  logic             err;

  modport master (
    output we, wdata, ra_sel, rb_sel, err_clr,
    input  ra_data, rb_data, err
  );

  modport slave (
    input  we, wdata, ra_sel, rb_sel, err_clr,
    output ra_data, rb_data, err
  );
endinterface

// File: rtl/reg_file_4x4.sv
// Four-entry register bank fed by a one-hot decoder, with two registered
// write-first read ports and a sticky flag for multi-hot write enables.
module reg_file_4x4 #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic           clk,
  input logic           rst,
  reg_file_4x4_if.slave bus
);
  logic [WIDTH-1:0] regs_q [4];
  logic [WIDTH-1:0] regs_d [4];
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic             err_q, err_d;
  logic             multi_hot;
  logic             one_hot;

  assign multi_hot = (bus.we & (bus.we - 4'd1)) != 4'd0;
  assign one_hot   = (bus.we != 4'd0) && !multi_hot;

  // Read ports look at the post-write array, which gives write-first bypass;
  // an illegal enable leaves regs_d untouched so nothing is forwarded.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      regs_d[i] = regs_q[i];
      if (one_hot && bus.we[i]) regs_d[i] = bus.wdata;
    end
    ra_d  = regs_d[bus.ra_sel];
    rb_d  = regs_d[bus.rb_sel];
    err_d = err_q;
    if (multi_hot)        err_d = 1'b1;
    else if (bus.err_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) regs_q[i] <= RESET_VAL;
      ra_q  <= RESET_VAL;
      rb_q  <= RESET_VAL;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) regs_q[i] <= regs_d[i];
      ra_q  <= ra_d;
      rb_q  <= rb_d;
      err_q <= err_d;
    end
  end

  assign bus.ra_data = ra_q;
  assign bus.rb_data = rb_q;
  assign bus.err     = err_q;
endmodule

// File: tb/tb_reg_file_4x4.sv
// Directed bench for reg_file_4x4: a behavioural model checked every cycle,
// plus literal expectations at the interesting points.
module tb_reg_file_4x4;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   checking = 1'b0;

  reg_file_4x4_if #(.WIDTH(4)) bus ();

  reg_file_4x4 #(.WIDTH(4), .RESET_VAL(4'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model straight from the rules: count enable bits, pick the
  // target if exactly one, read old contents unless the target matches.
  logic [3:0] m_reg [4] = '{default: 4'h0};
  logic [3:0] m_ra = 4'h0, m_rb = 4'h0;
  logic       m_err = 1'b0;
  int         m_tgt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_reg = '{default: 4'h0};
      m_ra  = 4'h0;
      m_rb  = 4'h0;
      m_err = 1'b0;
    end else begin
      m_tgt = -1;
      if ($countones(bus.we) == 1)
        for (int i = 0; i < 4; i++) if (bus.we[i]) m_tgt = i;
      m_ra = (m_tgt == int'(bus.ra_sel)) ? bus.wdata : m_reg[bus.ra_sel];
      m_rb = (m_tgt == int'(bus.rb_sel)) ? bus.wdata : m_reg[bus.rb_sel];
      if (m_tgt >= 0) m_reg[m_tgt] = bus.wdata;
      if ($countones(bus.we) >= 2) m_err = 1'b1;
      else if (bus.err_clr)        m_err = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checking && !rst) begin
      check("model_ra", bus.ra_data, m_ra);
      check("model_rb", bus.rb_data, m_rb);
      check("model_err", bus.err, m_err);
    end
  end

  task automatic cyc(input logic [3:0] we, input logic [3:0] wd,
                     input logic [1:0] ra, input logic [1:0] rb, input logic clr);
    bus.we      = we;
    bus.wdata   = wd;
    bus.ra_sel  = ra;
    bus.rb_sel  = rb;
    bus.err_clr = clr;
    @(posedge clk);
    #1;
  endtask

  logic [3:0] w_vals [4] = '{4'h1, 4'h2, 4'h4, 4'h8};

  initial begin
    rst         = 1'b1;
    bus.we      = 4'h0;
    bus.wdata   = 4'h0;
    bus.ra_sel  = 2'd0;
    bus.rb_sel  = 2'd0;
    bus.err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ra", bus.ra_data, 4'h0);
    check("rst_rb", bus.rb_data, 4'h0);
    check("rst_err", bus.err, 1'b0);
    rst      = 1'b0;
    checking = 1'b1;

    // One-hot writes R0..R3
    for (int i = 0; i < 4; i++) cyc(4'b0001 << i, w_vals[i], 2'd0, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(4'b0000, 4'h0, 2'(i), 2'(3 - i), 1'b0);
      check("read_ra", bus.ra_data, w_vals[i]);
      check("read_rb", bus.rb_data, w_vals[3 - i]);
    end

    // Illegal enable: no write, no bypass, err sets and sticks
    cyc(4'b0110, 4'hF, 2'd1, 2'd2, 1'b0);
    check("illegal_err", bus.err, 1'b1);
    check("illegal_ra", bus.ra_data, 4'h2);
    check("illegal_rb", bus.rb_data, 4'h4);
    for (int i = 0; i < 3; i++) begin
      cyc(4'b0000, 4'h0, 2'd1, 2'd2, 1'b0);
      check("err_sticky", bus.err, 1'b1);
    end
    check("illegal_r1", bus.ra_data, 4'h2);
    check("illegal_r2", bus.rb_data, 4'h4);

    // Set beats clear on the same edge
    cyc(4'b0011, 4'h5, 2'd0, 2'd1, 1'b1);
    check("prio_err", bus.err, 1'b1);
    check("prio_r0", bus.ra_data, 4'h1);
    cyc(4'b0000, 4'h0, 2'd0, 2'd1, 1'b1);
    check("clr_err", bus.err, 1'b0);

    // Bypass on a legal write, none on an illegal one
    cyc(4'b1000, 4'hA, 2'd3, 2'd2, 1'b0);
    check("byp_ra", bus.ra_data, 4'hA);
    check("byp_rb", bus.rb_data, 4'h4);
    cyc(4'b1000, 4'h8, 2'd0, 2'd0, 1'b0);
    cyc(4'b1100, 4'hA, 2'd3, 2'd2, 1'b0);
    check("nobyp_ra", bus.ra_data, 4'h8);
    check("nobyp_rb", bus.rb_data, 4'h4);
    check("nobyp_err", bus.err, 1'b1);

    // Idle: random data, no enables, same-select reads
    for (int i = 0; i < 10; i++) cyc(4'b0000, 4'($urandom_range(15)), 2'(i % 4), 2'(i % 4), 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(4'b0000, 4'($urandom_range(15)), 2'(i), 2'(i), 1'b0);
      check("idle_ra", bus.ra_data, w_vals[i]);
      check("idle_rb", bus.rb_data, w_vals[i]);
    end
    check("idle_err", bus.err, 1'b1);

    // Asynchronous reset mid-cycle, ahead of the next falling edge
    cyc(4'b0000, 4'h0, 2'd3, 2'd2, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("arst_ra", bus.ra_data, 4'h0);
    check("arst_rb", bus.rb_data, 4'h0);
    check("arst_err", bus.err, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("hold_ra", bus.ra_data, 4'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(4'b0000, 4'h0, 2'(i), 2'(3 - i), 1'b0);
      check("post_rst_ra", bus.ra_data, 4'h0);
      check("post_rst_rb", bus.rb_data, 4'h0);
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/reg_file_4x4.md
Name: reg_file_4x4

Overview:
Four-entry register bank for the 4-bit CPU. It sits directly downstream of the 2-to-4 write-address decoder. Its one-hot write-enable input is driven bit-for-bit by the decoder outputs d3..d0. It holds the architectural registers R0..R3 and provides two registered read ports for the ALU operand path. It also flags illegal (non-one-hot) write enables with a sticky error bit.

Parameters:
WIDTH, 4, data width of each register and of the read/write data ports
RESET_VAL, 0, value loaded into every register on reset (WIDTH bits)

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
we  input  4  one-hot write enable; we[i] is driven by decoder output d_i and selects register Ri
wdata  input  WIDTH  write data
ra_sel  input  2  read port A register select
rb_sel  input  2  read port B register select
ra_data  output  WIDTH  read port A data, registered
rb_data  output  WIDTH  read port B data, registered
err_clr  input  1  synchronous clear of err
err  output  1  sticky flag; set when a multi-hot we is seen

Behaviour:
- Reset: rst high asynchronously forces R0..R3 = RESET_VAL, ra_data = rb_data = RESET_VAL, err = 0. Reset takes effect immediately, including mid-operation. State holds while rst is high.
- Write, evaluated on each rising edge with rst low:
  - we = 0000: no write.
  - we with exactly one bit set (0001, 0010, 0100, 1000): Ri <= wdata for the set bit i. All other registers hold.
  - we with two or more bits set: no register is written, and err <= 1.
- err:
  - Sticky.
  - Cleared on a rising edge when err_clr = 1, unless a multi-hot we occurs on the same edge. Set has priority over clear.
  - err_clr does not affect the registers or the read ports.
- Read ports:
  - One-cycle latency: on each rising edge, ra_data <= R[ra_sel] and rb_data <= R[rb_sel].
  - Write-first bypass: if a legal one-hot write targets the register selected by ra_sel (or rb_sel) on the same edge, that port captures wdata, not the old contents.
  - A multi-hot (illegal) we never bypasses. The ports capture the unchanged register contents.
  - ra_sel and rb_sel may be equal. Both ports then return the same value on the same cycle.
- No handshake. Every port is sampled every cycle, and there are no stalls or backpressure.
- Outputs are driven only from flops. There is no combinational path from any input to ra_data, rb_data or err.
- Arithmetic: none. Data is stored and forwarded unmodified, exactly WIDTH bits, with no truncation or extension.

Test Plan:
- Reset: drive rst=1 mid-simulation after registers hold non-zero values -> ra_data=rb_data=0000 and err=0 immediately, without waiting for a clock edge. Then read all four registers -> 0000.
- One-hot writes: write R0=0x1 (we=0001), R1=0x2 (0010), R2=0x4 (0100), R3=0x8 (1000) on consecutive cycles. Then read ra_sel=0..3 with rb_sel=3..0 -> ra_data 1,2,4,8 and rb_data 8,4,2,1, each one cycle after its select.
- Illegal enable: with R1=0x2 and R2=0x4, drive we=0110 and wdata=0xF -> err=1 after the edge, and R1/R2 are unchanged (read back 0x2/0x4). Hold err_clr=0 for 3 cycles -> err stays 1.
- Clear vs set priority: with err=1, pulse err_clr=1 while we=0011 -> err stays 1. Then pulse err_clr=1 with we=0000 -> err=0 on the next edge.
- Bypass: with R3=0x8, set ra_sel=3, rb_sel=2, we=1000, wdata=0xA on one edge -> ra_data=0xA after that edge and rb_data=R2. Repeat with we=1100 -> ra_data=0x8 (no bypass) and err=1.
- No-write idle: drive we=0000 with random wdata for 10 cycles -> all four registers unchanged and err unchanged.
